// File: rtl/bell_arbiter_pkg.sv
// Shared types and constants for the two-button doorbell arbiter.
// Holds the playback state encoding, the source indices and the default
// timing parameters used by the arbiter and its tone generator.
package bell_pkg;

  // Playback state: waiting for a request, sounding a burst, or silent gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } bell_state_t;

  // Source indices. These match the bit positions in grant and pend.
  localparam int SRC_BTN1 = 0;
  localparam int SRC_BTN2 = 1;

  // Default timing, all in clk cycles or burst counts.
  localparam int DEF_TONE_HALF1 = 25;
  localparam int DEF_TONE_HALF2 = 40;
  localparam int DEF_BURST_CYC  = 2000;
  localparam int DEF_GAP_CYC    = 1000;
  localparam int DEF_NBURST1    = 2;
  localparam int DEF_NBURST2    = 3;

  // Larger of two integers. Used to size counters that serve both sources.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bell_arbiter_if.sv
// Button and speaker-side signal bundle of the doorbell arbiter.
// The master side drives the buttons and observes status.
// The slave side is the arbiter itself.
interface bell_arbiter_if;
  logic       btn1;   // front-door button level
  logic       btn2;   // back-door button level
  logic       out;    // tone output to the speaker
  logic       busy;   // pattern playing (TONE or GAP)
  logic [1:0] grant;  // one-hot source now playing, 00 when idle
  logic [1:0] pend;   // pending request flags

  modport master (
    output btn1,
    output btn2,
    input  out,
    input  busy,
    input  grant,
    input  pend
  );

  modport slave (
    input  btn1,
    input  btn2,
    output out,
    output busy,
    output grant,
    output pend
  );
endinterface

// File: rtl/bell_tone_gen.sv
// Square-wave generator for the doorbell tone.
// Counts half periods and toggles a flop at the end of each one.
// While disabled, both the counter and the flop are held cleared, so every
// enable starts a fresh wave at 0. The first rise comes half_period cycles
// after enable goes high.
module bell_tone_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] half_period,
  output logic         tone
);

  logic [W-1:0] r_cnt;
  logic         r_tone;
  logic         w_wrap;

  // The last cycle of a half period is reached at half_period-1.
  assign w_wrap = (r_cnt == (half_period - W'(1)));

  // Half-period counter and toggle flop. Both are cleared while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_cnt  <= r_cnt + W'(1);
    end
  end

  // Gate with en so the output is 0 in the first disabled cycle too, even if
  // the flop toggled on the edge that ended the burst.
  assign tone = r_tone & en;

endmodule

// File: rtl/bell_arbiter.sv
// Two-button doorbell arbiter.
// It detects button presses and keeps one pending request per source.
// When both sources wait, it grants the shared tone output round-robin.
// It then plays the granted source's chime: NBURST_i tone bursts, each
// followed by a silent gap.
module bell_arbiter
  import bell_pkg::*;
#(
  parameter int TONE_HALF1 = DEF_TONE_HALF1,
  parameter int TONE_HALF2 = DEF_TONE_HALF2,
  parameter int BURST_CYC  = DEF_BURST_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int NBURST1    = DEF_NBURST1,
  parameter int NBURST2    = DEF_NBURST2
) (
  input  logic           clk,
  input  logic           rst,
  bell_arbiter_if.slave  bus
);

  // Counter widths. Each counter is shared by both sources, so it is sized
  // for the larger value.
  localparam int PH_W = $clog2(max2(BURST_CYC, GAP_CYC) + 1);
  localparam int NB_W = $clog2(max2(NBURST1, NBURST2) + 1);
  localparam int TH_W = $clog2(max2(TONE_HALF1, TONE_HALF2) + 1);

  // Reject zero or negative timing at elaboration. A zero value would make a
  // down-counter wrap and stall the pattern.
  if (TONE_HALF1 < 1 || TONE_HALF2 < 1 || BURST_CYC < 1 || GAP_CYC < 1 ||
      NBURST1 < 1 || NBURST2 < 1) begin : g_bad_param
    $error("bell_arbiter: every timing parameter must be >= 1");
  end

  logic [1:0]      w_btn;
  logic [1:0]      w_rise;
  logic [1:0]      r_pend;
  logic [1:0]      w_pend_next;
  logic [1:0]      w_grant_clr;
  bell_state_t     r_state;
  bell_state_t     w_state_next;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_phase_next;
  logic [NB_W-1:0] r_burst;
  logic [NB_W-1:0] w_burst_next;
  logic            r_last;
  logic            w_last_next;
  logic            r_src;
  logic            w_src_next;
  logic            w_sel;
  logic [TH_W-1:0] w_half;
  logic            w_tone_en;
  logic            w_tone;

  assign w_btn = {bus.btn2, bus.btn1};

  // Per-button edge detector.
  // r_armed stays low until the button is sampled low after reset. Without it,
  // a button that is still held when reset releases would look like a new
  // press, because r_btn_q resets to 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic r_btn_q;
    logic r_armed;

    // Track the previous level and arm once the button has been seen low.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_btn_q <= 1'b0;
        r_armed <= 1'b0;
      end else begin
        r_btn_q <= w_btn[gi];
        if (!w_btn[gi]) begin
          r_armed <= 1'b1;
        end
      end
    end

    assign w_rise[gi] = w_btn[gi] & ~r_btn_q & r_armed;
  end

  // A new press in the cycle its grant clears pend keeps the flag set, so
  // the press is not lost.
  assign w_pend_next = (r_pend & ~w_grant_clr) | w_rise;

  // Pending request flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 2'b00;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // Playback state, phase and burst counters, round-robin pointer, and the
  // current source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_burst <= '0;
      r_last  <= 1'b1;
      r_src   <= 1'(SRC_BTN1);
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_burst <= w_burst_next;
      r_last  <= w_last_next;
      r_src   <= w_src_next;
    end
  end

  // Next-state logic.
  // IDLE arbitrates. TONE and GAP count their phase down to 1, so each
  // phase lasts exactly its cycle count.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_burst_next = r_burst;
    w_last_next  = r_last;
    w_src_next   = r_src;
    w_grant_clr  = 2'b00;
    w_sel        = 1'(SRC_BTN1);

    case (r_state)
      IDLE: begin
        if (r_pend != 2'b00) begin
          // On a tie, take the source that did not play last. Otherwise take
          // the only requester.
          if (r_pend == 2'b11) begin
            w_sel = ~r_last;
          end else begin
            w_sel = r_pend[SRC_BTN2];
          end
          w_state_next = TONE;
          w_phase_next = PH_W'(BURST_CYC);
          w_burst_next = (w_sel == 1'(SRC_BTN2)) ? NB_W'(NBURST2) : NB_W'(NBURST1);
          w_last_next  = w_sel;
          w_src_next   = w_sel;
          w_grant_clr  = (w_sel == 1'(SRC_BTN2)) ? 2'b10 : 2'b01;
        end
      end

      TONE: begin
        if (r_phase == PH_W'(1)) begin
          w_state_next = GAP;
          w_phase_next = PH_W'(GAP_CYC);
        end else begin
          w_phase_next = r_phase - PH_W'(1);
        end
      end

      GAP: begin
        if (r_phase == PH_W'(1)) begin
          // Check the count before decrementing: a count of 1 means this was
          // the final gap of the pattern.
          if (r_burst == NB_W'(1)) begin
            w_state_next = IDLE;
            w_burst_next = '0;
            w_phase_next = '0;
          end else begin
            w_state_next = TONE;
            w_burst_next = r_burst - NB_W'(1);
            w_phase_next = PH_W'(BURST_CYC);
          end
        end else begin
          w_phase_next = r_phase - PH_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_phase_next = '0;
        w_burst_next = '0;
      end
    endcase
  end

  // The divider runs only in TONE. Leaving TONE clears it, so each burst
  // starts its wave at 0.
  assign w_tone_en = (r_state == TONE);
  assign w_half    = (r_src == 1'(SRC_BTN2)) ? TH_W'(TONE_HALF2) : TH_W'(TONE_HALF1);

  bell_tone_gen #(
    .W (TH_W)
  ) u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (w_tone_en),
    .half_period (w_half),
    .tone        (w_tone)
  );

  // Status outputs are decoded straight from registers, so the asynchronous
  // reset clears them immediately.
  assign bus.out   = w_tone;
  assign bus.busy  = (r_state != IDLE);
  assign bus.grant = (r_state == IDLE) ? 2'b00 :
                     ((r_src == 1'(SRC_BTN2)) ? 2'b10 : 2'b01);
  assign bus.pend  = r_pend;

endmodule

// File: tb/tb_bell_arbiter.sv
// Directed testbench for bell_arbiter, run with shortened timing.
// btn1 : half period 3, bursts 24, gap 10, 2 bursts  -> 8 toggles/burst, 68-cycle pattern
// btn2 : half period 4, bursts 24, gap 10, 3 bursts  -> 6 toggles/burst, 102-cycle pattern
module tb_bell_arbiter;

  localparam int TH1 = 3;
  localparam int TH2 = 4;
  localparam int BC  = 24;
  localparam int GC  = 10;
  localparam int NB1 = 2;
  localparam int NB2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tog   = 0;
  logic prev_out = 1'b0;

  bell_arbiter_if bus ();

  bell_arbiter #(
    .TONE_HALF1 (TH1),
    .TONE_HALF2 (TH2),
    .BURST_CYC  (BC),
    .GAP_CYC    (GC),
    .NBURST1    (NB1),
    .NBURST2    (NB2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and count out changes.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.out !== prev_out) tog++;
    prev_out = bus.out;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.btn1 = 1'b0;
    bus.btn2 = 1'b0;
    steps(2);
    chk($sformatf("%s reset out", tag),   32'(bus.out),   0);
    chk($sformatf("%s reset busy", tag),  32'(bus.busy),  0);
    chk($sformatf("%s reset grant", tag), 32'(bus.grant), 0);
    chk($sformatf("%s reset pend", tag),  32'(bus.pend),  0);
    rst = 1'b0;
    steps(2);
  endtask

  // Entered right after the grant edge. Walks a whole pattern and checks the
  // toggle count of every burst, a silent gap, the first-toggle timing and the
  // busy level at each gap end.
  task automatic play(input string tag, input int nb, input int half, input logic [1:0] g);
    for (int b = 0; b < nb; b++) begin
      tog = 0;
      for (int k = 1; k <= BC; k++) begin
        step();
        if (b == 0 && k == half - 1) chk($sformatf("%s out low before first toggle", tag), 32'(bus.out), 0);
        if (b == 0 && k == half)     chk($sformatf("%s first toggle", tag), 32'(bus.out), 1);
        if (k == BC - 1)             chk($sformatf("%s grant b%0d", tag, b), 32'(bus.grant), 32'(g));
      end
      chk($sformatf("%s burst%0d toggles", tag, b), 32'(tog), 32'(BC / half));
      tog = 0;
      steps(GC);
      chk($sformatf("%s gap%0d toggles", tag, b), 32'(tog), 0);
      chk($sformatf("%s busy after gap%0d", tag, b), 32'(bus.busy), (b == nb - 1) ? 0 : 1);
    end
    chk($sformatf("%s grant cleared", tag), 32'(bus.grant), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.btn1 = 1'b0;
    bus.btn2 = 1'b0;

    // T1: single btn1 pulse
    do_reset("t1");
    bus.btn1 = 1'b1; step();
    chk("t1 pend set", 32'(bus.pend), 1);
    chk("t1 still idle", 32'(bus.busy), 0);
    bus.btn1 = 1'b0; step();
    chk("t1 grant", 32'(bus.grant), 1);
    chk("t1 busy", 32'(bus.busy), 1);
    chk("t1 pend cleared", 32'(bus.pend), 0);
    play("t1", NB1, TH1, 2'b01);

    // T2: simultaneous rise after reset -> btn1 first (last resets to btn2)
    do_reset("t2");
    bus.btn1 = 1'b1; bus.btn2 = 1'b1; step();
    chk("t2 pend both", 32'(bus.pend), 3);
    bus.btn1 = 1'b0; bus.btn2 = 1'b0; step();
    chk("t2 first grant", 32'(bus.grant), 1);
    chk("t2 pend btn2 left", 32'(bus.pend), 2);
    play("t2a", NB1, TH1, 2'b01);
    chk("t2 btn2 still pending", 32'(bus.pend), 2);
    step();
    chk("t2 second grant", 32'(bus.grant), 2);
    chk("t2 pend empty", 32'(bus.pend), 0);
    play("t2b", NB2, TH2, 2'b10);

    // T3: round-robin with btn1 last granted -> btn2 wins the tie
    do_reset("t3");
    bus.btn1 = 1'b1; step();
    bus.btn1 = 1'b0; step();
    chk("t3 lone btn1 grant", 32'(bus.grant), 1);
    play("t3a", NB1, TH1, 2'b01);
    bus.btn1 = 1'b1; bus.btn2 = 1'b1; step();
    bus.btn1 = 1'b0; bus.btn2 = 1'b0; step();
    chk("t3 tie goes to btn2", 32'(bus.grant), 2);
    play("t3b", NB2, TH2, 2'b10);
    step();
    chk("t3 then btn1", 32'(bus.grant), 1);
    play("t3c", NB1, TH1, 2'b01);

    // T4: coalescing; btn2 held, btn1 pulsed three times during btn2 playback
    bus.btn2 = 1'b1; step(); step();
    chk("t4 btn2 grant", 32'(bus.grant), 2);
    steps(10);
    repeat (3) begin
      bus.btn1 = 1'b1; step();
      bus.btn1 = 1'b0; step();
    end
    chk("t4 pend coalesced", 32'(bus.pend), 1);
    steps(102 - 16 - 1);
    chk("t4 last gap cycle busy", 32'(bus.busy), 1);
    step();
    chk("t4 btn2 done", 32'(bus.busy), 0);
    chk("t4 btn1 pending", 32'(bus.pend), 1);
    step();
    chk("t4 btn1 replay grant", 32'(bus.grant), 1);
    play("t4", NB1, TH1, 2'b01);
    steps(5);
    chk("t4 no btn2 replay busy", 32'(bus.busy), 0);
    chk("t4 no btn2 replay pend", 32'(bus.pend), 0);
    bus.btn2 = 1'b0;

    // T5: self-replay; btn1 pressed mid-pattern
    bus.btn1 = 1'b1; step();
    bus.btn1 = 1'b0; step();
    chk("t5 grant", 32'(bus.grant), 1);
    steps(30);
    bus.btn1 = 1'b1; step();
    bus.btn1 = 1'b0;
    chk("t5 pend during own play", 32'(bus.pend), 1);
    steps(68 - 31 - 1);
    chk("t5 pend held to end", 32'(bus.pend), 1);
    step();
    chk("t5 pattern ended", 32'(bus.busy), 0);
    step();
    chk("t5 replay grant", 32'(bus.grant), 1);
    chk("t5 replay pend cleared", 32'(bus.pend), 0);
    play("t5", NB1, TH1, 2'b01);

    // T6: reset mid-burst with both buttons held through and after reset
    bus.btn1 = 1'b1; step();
    bus.btn1 = 1'b0; step();
    chk("t6 grant", 32'(bus.grant), 1);
    steps(10);
    bus.btn2 = 1'b1; step();
    chk("t6 out high before reset", 32'(bus.out), 1);
    chk("t6 pend btn2", 32'(bus.pend), 2);
    bus.btn1 = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6 async out", 32'(bus.out), 0);
    chk("t6 async busy", 32'(bus.busy), 0);
    chk("t6 async grant", 32'(bus.grant), 0);
    chk("t6 async pend", 32'(bus.pend), 0);
    steps(3);
    rst = 1'b0;
    tog = 0;
    steps(20);
    chk("t6 held buttons no busy", 32'(bus.busy), 0);
    chk("t6 held buttons no pend", 32'(bus.pend), 0);
    chk("t6 no out activity", 32'(tog), 0);
    bus.btn1 = 1'b0; bus.btn2 = 1'b0; step();
    bus.btn1 = 1'b1; step();
    chk("t6 fresh press pend", 32'(bus.pend), 1);
    bus.btn1 = 1'b0; step();
    chk("t6 fresh press grant", 32'(bus.grant), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
